// File: rtl/tape_punch.sv
`default_nettype none
// ============================================================================
//  Module   : tape_punch
//  Brief    : Bus initiator that reads a byte block from main memory one word
//             at a time and streams the bytes, most significant lane first,
//             to a paper-tape punch over a valid/ready handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module tape_punch #(
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   active,
    input  logic                   start,
    input  logic [18:0]            start_byte,
    input  logic [COUNT_WIDTH-1:0] byte_count,
    output logic [16:0]            memory_address,
    input  logic [31:0]            memory_data_out,
    output logic [3:0]             mem_write_en,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic                   busy,
    output logic                   done
);

    localparam logic [COUNT_WIDTH-1:0] c_one = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_SEND = 3'd3,
        S_FIN  = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;
    logic [16:0]            r_word_addr;
    logic [1:0]             r_lane;
    logic [COUNT_WIDTH-1:0] r_remaining;
    logic [31:0]            r_word;
    logic                   r_busy;
    logic                   r_done;
    logic                   w_accept;
    logic                   w_handshake;
    logic [7:0]             w_lane_byte;

    // State register; reset aborts any transfer immediately.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic plus the start-accept and byte-handshake strobes.
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_handshake  = 1'b0;
        case (r_state)
            S_IDLE: begin
                // busy is still high for the cycle after done, so a start
                // arriving then is ignored.
                if (start && !r_busy) begin
                    w_accept     = 1'b1;
                    w_next_state = (byte_count == '0) ? S_FIN : S_REQ;
                end
            end
            S_REQ: begin
                if (active) begin
                    w_next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                w_next_state = S_SEND;
            end
            S_SEND: begin
                if (tx_ready) begin
                    w_handshake = 1'b1;
                    if (r_remaining == c_one) begin
                        w_next_state = S_FIN;
                    end else if (r_lane == 2'd3) begin
                        w_next_state = S_REQ;
                    end
                end
            end
            S_FIN: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Transfer bookkeeping: address, lane, remaining count and word buffer.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_word_addr <= '0;
            r_lane      <= '0;
            r_remaining <= '0;
            r_word      <= '0;
        end else begin
            if (w_accept) begin
                r_word_addr <= start_byte[18:2];
                r_lane      <= start_byte[1:0];
                r_remaining <= byte_count;
            end
            // RAM data is valid one edge after the address was sampled in
            // REQ; grant is irrelevant by then.
            if (r_state == S_WAIT) begin
                r_word <= memory_data_out;
            end
            if (w_handshake) begin
                r_remaining <= r_remaining - c_one;
                r_lane      <= r_lane + 2'd1;
                if (r_lane == 2'd3) begin
                    r_word_addr <= r_word_addr + 17'd1;
                end
            end
        end
    end

    // Status flags: done pulses the cycle after FIN, busy drops one cycle later.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state == S_FIN);
            if (w_accept) begin
                r_busy <= 1'b1;
            end else if (r_done) begin
                r_busy <= 1'b0;
            end
        end
    end

    // Big-endian lane select: lane 0 is the most significant byte.
    always_comb begin
        w_lane_byte = 8'h00;
        case (r_lane)
            2'd0:    w_lane_byte = r_word[31:24];
            2'd1:    w_lane_byte = r_word[23:16];
            2'd2:    w_lane_byte = r_word[15:8];
            default: w_lane_byte = r_word[7:0];
        endcase
    end

    assign memory_address = (r_state == S_REQ) ? r_word_addr : 17'd0;
    assign mem_write_en   = 4'b0000;
    assign tx_valid       = (r_state == S_SEND);
    assign tx_data        = tx_valid ? w_lane_byte : 8'h00;
    assign busy           = r_busy;
    assign done           = r_done;

endmodule
`default_nettype wire

// File: tb/tb_tape_punch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tape_punch
//  Brief    : Directed, scoreboard-based bench for tape_punch.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_tape_punch;

    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          active = 1'b1;
    logic          start = 1'b0;
    logic          tx_ready = 1'b1;
    logic [18:0]   start_byte = '0;
    logic [CW-1:0] byte_count = '0;
    logic [16:0]   memory_address;
    logic [31:0]   memory_data_out = '0;
    logic [3:0]    mem_write_en;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int done_cnt = 0;
    int rise_cnt = 0;
    int hs_cnt = 0;
    int hs_cyc = 0;
    int done_cyc = 0;
    logic       prev_valid = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    logic [7:0]  exp_q[$];
    logic [31:0] ram [int];

    always #5 clock = ~clock;

    tape_punch #(.COUNT_WIDTH(CW)) dut (
        .clock           (clock),
        .reset           (reset),
        .active          (active),
        .start           (start),
        .start_byte      (start_byte),
        .byte_count      (byte_count),
        .memory_address  (memory_address),
        .memory_data_out (memory_data_out),
        .mem_write_en    (mem_write_en),
        .tx_data         (tx_data),
        .tx_valid        (tx_valid),
        .tx_ready        (tx_ready),
        .busy            (busy),
        .done            (done)
    );

    function automatic logic [31:0] rd(input logic [16:0] a);
        if (ram.exists(int'(a))) return ram[int'(a)];
        return 32'hA5A5A5A5;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Synchronous-read RAM model.
    always @(posedge clock) begin
        cyc++;
        memory_data_out <= rd(memory_address);
    end

    // Output monitor: scoreboard pops, hold-under-backpressure, pulse counts.
    always @(negedge clock) begin
        chk("wen", {28'd0, mem_write_en}, 32'd0);
        if (reset) begin
            if (prev_stall) begin
                chk("hold_valid", {31'd0, tx_valid}, 32'd1);
                chk("hold_data", {24'd0, tx_data}, {24'd0, prev_data});
            end
            if (tx_valid && !prev_valid) rise_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (tx_valid && tx_ready) begin
                hs_cnt++;
                hs_cyc = cyc;
                if (exp_q.size() == 0) chk("extra_byte", exp_q.size(), 32'd1);
                else chk("byte", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
            prev_valid = tx_valid;
        end else begin
            prev_stall = 1'b0;
            prev_valid = 1'b0;
        end
    end

    // Push the expected byte stream, then pulse start for one cycle.
    task automatic do_start(input logic [18:0] sb, input int cnt);
        logic [16:0] a;
        logic [31:0] w;
        int ln;
        a  = sb[18:2];
        ln = int'(sb[1:0]);
        for (int i = 0; i < cnt; i++) begin
            w = rd(a);
            exp_q.push_back(w[31-8*ln -: 8]);
            ln++;
            if (ln == 4) begin
                ln = 0;
                a  = a + 17'd1;
            end
        end
        @(posedge clock); #1;
        start_byte = sb;
        byte_count = CW'(cnt);
        start      = 1'b1;
        @(posedge clock); #1;
        start      = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget && busy; i++) begin
            @(negedge clock); #1;
        end
        if (busy) chk("timeout_idle", {31'd0, busy}, 32'd0);
    endtask

    // Wait for the second address phase (first REQ after a word was sent).
    task automatic wait_next_req(input int r0);
        for (int i = 0; i < 30 && !(rise_cnt > r0 && !tx_valid); i++) begin
            @(negedge clock); #1;
        end
        if (!(rise_cnt > r0 && !tx_valid)) chk("timeout_req", rise_cnt - r0, 32'd1);
    endtask

    int d0, r0, h0;

    initial begin
        ram[32'h40]    = 32'h11223344;
        ram[32'h41]    = 32'h55667788;
        ram[32'h42]    = 32'h99AABBCC;
        ram[32'h1FFFF] = 32'hDEADBEEF;
        ram[32'h0]     = 32'hCAFEF00D;

        // Reset state
        #2;
        chk("rst_addr", {15'd0, memory_address}, 32'd0);
        chk("rst_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_data", {24'd0, tx_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Aligned block of two words
        d0 = done_cnt; r0 = rise_cnt; h0 = hs_cnt;
        do_start(19'h100, 8);
        @(negedge clock); #1;
        chk("al_addr0", {15'd0, memory_address}, 32'h40);
        chk("al_busy", {31'd0, busy}, 32'd1);
        wait_next_req(r0);
        chk("al_addr1", {15'd0, memory_address}, 32'h41);
        wait_idle(100);
        chk("al_done_cnt", done_cnt - d0, 32'd1);
        chk("al_done_lat", done_cyc - hs_cyc, 32'd2);
        chk("al_reads", rise_cnt - r0, 32'd2);
        chk("al_bytes", hs_cnt - h0, 32'd8);
        chk("al_q_empty", exp_q.size(), 32'd0);

        // Unaligned start with a partial last word
        r0 = rise_cnt; h0 = hs_cnt;
        do_start(19'h102, 3);
        @(negedge clock); #1;
        chk("ua_addr0", {15'd0, memory_address}, 32'h40);
        wait_idle(100);
        chk("ua_reads", rise_cnt - r0, 32'd2);
        chk("ua_bytes", hs_cnt - h0, 32'd3);
        chk("ua_q_empty", exp_q.size(), 32'd0);

        // Backpressure with ready pattern 1,0,0,1
        h0 = hs_cnt;
        do_start(19'h100, 8);
        for (int i = 0; i < 200 && busy; i++) begin
            tx_ready = (i % 4 == 0) || (i % 4 == 3);
            @(posedge clock); #1;
        end
        tx_ready = 1'b1;
        wait_idle(50);
        chk("bp_bytes", hs_cnt - h0, 32'd8);
        chk("bp_q_empty", exp_q.size(), 32'd0);

        // Grant withheld while in REQ
        active = 1'b0;
        do_start(19'h100, 4);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock); #1;
            chk("gr_addr_hold", {15'd0, memory_address}, 32'h40);
            chk("gr_no_valid", {31'd0, tx_valid}, 32'd0);
        end
        @(posedge clock); #1;
        active = 1'b1;
        @(negedge clock); #1;
        chk("gr_addr_sampled", {15'd0, memory_address}, 32'h40);
        @(negedge clock); #1;
        chk("gr_wait_valid", {31'd0, tx_valid}, 32'd0);
        @(negedge clock); #1;
        chk("gr_first_valid", {31'd0, tx_valid}, 32'd1);
        chk("gr_first_data", {24'd0, tx_data}, 32'h11);
        wait_idle(50);
        chk("gr_q_empty", exp_q.size(), 32'd0);

        // Zero count
        d0 = done_cnt; r0 = rise_cnt;
        do_start(19'h100, 0);
        @(negedge clock); #1;
        chk("z_busy", {31'd0, busy}, 32'd1);
        chk("z_addr", {15'd0, memory_address}, 32'd0);
        chk("z_valid", {31'd0, tx_valid}, 32'd0);
        wait_idle(20);
        chk("z_done_cnt", done_cnt - d0, 32'd1);
        chk("z_no_read", rise_cnt - r0, 32'd0);

        // Word address wrap
        r0 = rise_cnt;
        do_start(19'h7FFFC, 8);
        @(negedge clock); #1;
        chk("wr_addr0", {15'd0, memory_address}, 32'h1FFFF);
        wait_next_req(r0);
        chk("wr_addr1", {15'd0, memory_address}, 32'h0);
        wait_idle(100);
        chk("wr_q_empty", exp_q.size(), 32'd0);

        // Asynchronous reset mid-SEND
        d0 = done_cnt; r0 = rise_cnt;
        tx_ready = 1'b0;
        do_start(19'h100, 8);
        for (int i = 0; i < 20 && !tx_valid; i++) begin
            @(negedge clock); #1;
        end
        chk("rs_in_send", {31'd0, tx_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("rs_valid", {31'd0, tx_valid}, 32'd0);
        chk("rs_busy", {31'd0, busy}, 32'd0);
        chk("rs_addr", {15'd0, memory_address}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clock);
        #1;
        reset    = 1'b1;
        tx_ready = 1'b1;
        repeat (4) @(negedge clock);
        #1;
        chk("rs_no_done", done_cnt - d0, 32'd0);
        h0 = hs_cnt;
        do_start(19'h100, 8);
        wait_idle(100);
        chk("rs_rerun_done", done_cnt - d0, 32'd1);
        chk("rs_rerun_bytes", hs_cnt - h0, 32'd8);
        chk("rs_q_empty", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
